// File: rtl/receptor_serie_tupla_pkg.sv
// Shared definitions for the serial tuple receiver: FSM state encodings and
// default frame geometry, also used by the downstream 4-bit register stage.
package receptor_serie_tupla_pkg;

    // Default frame geometry: 4 data bits followed by an even parity bit.
    localparam int ANCHO_DEF   = 4;
    localparam int PARIDAD_DEF = 1;

    // FSM state encodings.
    localparam int ESTADO_W = 2;
    localparam logic [1:0] ST_REPOSO  = 2'd0;  // line idle, waiting for a start bit
    localparam logic [1:0] ST_DATOS   = 2'd1;  // shifting in data bits, LSB first
    localparam logic [1:0] ST_PARIDAD = 2'd2;  // sampling the even parity bit
    localparam logic [1:0] ST_PARADA  = 2'd3;  // sampling the stop bit

endpackage : receptor_serie_tupla_pkg

// File: rtl/receptor_serie_tupla_contador_bits.sv
// Modulo-MODULO up-counter that tracks the data bit index inside a frame.
// Synchronous clear wins over enable; tc flags the last index (MODULO-1).
module contador_bits #(
    parameter int MODULO = 4,
    parameter int CW     = (MODULO > 1) ? $clog2(MODULO) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] cnt_o,
    output logic          tc_o
);

    localparam logic [CW-1:0] ULTIMO = CW'(MODULO - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear, hold, or advance with wrap at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == ULTIMO) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == ULTIMO);

endmodule : contador_bits

// File: rtl/receptor_serie_tupla.sv
// Serial-to-parallel receiver: start bit, ANCHO data bits LSB first, optional
// even parity bit, stop bit. Each good frame lands on Tupla together with a
// one-cycle Habilitar strobe that directly loads the register stage.
//
// Handshake: Habilitar is a push-only valid with no ready. It is high for
// exactly one Reloj cycle, the cycle after the edge that samples a good stop
// bit, and Tupla is stable from that cycle until the next good frame. The
// consumer must accept every strobe; there is no back-pressure.
module receptor_serie_tupla
    import receptor_serie_tupla_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int PARIDAD = PARIDAD_DEF
) (
    input  logic                Reloj,
    input  logic                Reiniciar,
    input  logic                DatoSerie,
    input  logic                Muestra,
    output logic [ANCHO-1:0]    Tupla,
    output logic                Habilitar,
    output logic                Ocupado,
    output logic                ErrorParidad,
    output logic                ErrorTrama,
    output logic [ESTADO_W-1:0] EstadoDepuracion
);

    localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

    logic [ESTADO_W-1:0] estado_q, estado_d;
    logic [ANCHO-1:0]    desplaz_q, desplaz_d;
    logic [ANCHO-1:0]    tupla_q, tupla_d;
    logic                hab_q, hab_d;
    logic                ocupado_q, ocupado_d;
    logic                err_par_q, err_par_d;
    logic                err_trama_q, err_trama_d;

    logic                cnt_clr;
    logic                cnt_en;
    logic [CW-1:0]       cnt;
    logic                cnt_tc;

    // The counter restarts on an accepted tick in REPOSO and advances once per
    // data bit, so it reads ANCHO-1 exactly when the last data bit is sampled.
    assign cnt_clr = Muestra && (estado_q == ST_REPOSO);
    assign cnt_en  = Muestra && (estado_q == ST_DATOS);

    contador_bits #(
        .MODULO (ANCHO),
        .CW     (CW)
    ) u_contador_bits (
        .clk_i  (Reloj),
        .rst_i  (Reiniciar),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt),
        .tc_o   (cnt_tc)
    );

    // Frame FSM, shift register and output register next-state logic.
    always_comb begin
        estado_d    = estado_q;
        desplaz_d   = desplaz_q;
        tupla_d     = tupla_q;
        hab_d       = 1'b0;
        ocupado_d   = ocupado_q;
        err_par_d   = err_par_q;
        err_trama_d = err_trama_q;

        if (Muestra) begin
            case (estado_q)
                ST_REPOSO: begin
                    // A single low sample is taken as the start bit.
                    if (!DatoSerie) begin
                        estado_d    = ST_DATOS;
                        ocupado_d   = 1'b1;
                        err_par_d   = 1'b0;
                        err_trama_d = 1'b0;
                    end
                end
                ST_DATOS: begin
                    // Shifting in at the MSB leaves the first bit in the LSB.
                    desplaz_d = {DatoSerie, desplaz_q[ANCHO-1:1]};
                    if (cnt_tc) begin
                        estado_d = (PARIDAD != 0) ? ST_PARIDAD : ST_PARADA;
                    end
                end
                ST_PARIDAD: begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    err_par_d = (^desplaz_q) ^ DatoSerie;
                    estado_d  = ST_PARADA;
                end
                ST_PARADA: begin
                    err_trama_d = ~DatoSerie;
                    ocupado_d   = 1'b0;
                    estado_d    = ST_REPOSO;
                    // A bad frame leaves the previous word in place.
                    if (DatoSerie && !err_par_q) begin
                        tupla_d = desplaz_q;
                        hab_d   = 1'b1;
                    end
                end
                default: begin
                    estado_d  = ST_REPOSO;
                    ocupado_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge Reloj) begin
        if (Reiniciar) begin
            estado_q    <= ST_REPOSO;
            desplaz_q   <= '0;
            tupla_q     <= '0;
            hab_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            err_par_q   <= 1'b0;
            err_trama_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            desplaz_q   <= desplaz_d;
            tupla_q     <= tupla_d;
            hab_q       <= hab_d;
            ocupado_q   <= ocupado_d;
            err_par_q   <= err_par_d;
            err_trama_q <= err_trama_d;
        end
    end

    assign Tupla            = tupla_q;
    assign Habilitar        = hab_q;
    assign Ocupado          = ocupado_q;
    assign ErrorParidad     = err_par_q;
    assign ErrorTrama       = err_trama_q;
    assign EstadoDepuracion = estado_q;

endmodule : receptor_serie_tupla

// File: tb/tb_receptor_serie_tupla.sv
// Directed bench for receptor_serie_tupla: one instance with parity (ANCHO=4,
// PARIDAD=1) and one without (PARIDAD=0), sharing clock and reset.
module tb_receptor_serie_tupla;

    // ---------------- clock / reset ----------------
    logic       Reloj;
    logic       Reiniciar;
    int         cyc;

    initial begin
        Reloj = 1'b0;
        forever #5 Reloj = ~Reloj;
    end

    always @(posedge Reloj) cyc <= cyc + 1;

    // ---------------- DUTs ----------------
    logic       ds, mu;
    logic [3:0] tupla;
    logic       hab, ocup, epar, etrama;
    logic [1:0] estado;

    logic       ds0, mu0;
    logic [3:0] tupla0;
    logic       hab0, ocup0, epar0, etrama0;
    logic [1:0] estado0;

    receptor_serie_tupla #(.ANCHO(4), .PARIDAD(1)) dut (
        .Reloj            (Reloj),
        .Reiniciar        (Reiniciar),
        .DatoSerie        (ds),
        .Muestra          (mu),
        .Tupla            (tupla),
        .Habilitar        (hab),
        .Ocupado          (ocup),
        .ErrorParidad     (epar),
        .ErrorTrama       (etrama),
        .EstadoDepuracion (estado)
    );

    receptor_serie_tupla #(.ANCHO(4), .PARIDAD(0)) dut_np (
        .Reloj            (Reloj),
        .Reiniciar        (Reiniciar),
        .DatoSerie        (ds0),
        .Muestra          (mu0),
        .Tupla            (tupla0),
        .Habilitar        (hab0),
        .Ocupado          (ocup0),
        .ErrorParidad     (epar0),
        .ErrorTrama       (etrama0),
        .EstadoDepuracion (estado0)
    );

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [3:0] exp_q[$];
    logic [3:0] exp_q0[$];

    // Every strobe must be anticipated and carry the next expected word.
    always @(negedge Reloj) begin
        if (hab) begin
            chk("strobe_expected", hab, exp_q.size() != 0);
            if (exp_q.size() != 0) chk("strobe_tupla", tupla, exp_q.pop_front());
        end
        if (hab0) begin
            chk("strobe_expected_np", hab0, exp_q0.size() != 0);
            if (exp_q0.size() != 0) chk("strobe_tupla_np", tupla0, exp_q0.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge Reloj);
        #1;
    endtask

    // Sends n bits, leftmost literal bit first, one tick per cycle.
    task automatic send(input int sel, input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin
                ds = bits[n-1-i];
                mu = 1'b1;
            end else begin
                ds0 = bits[n-1-i];
                mu0 = 1'b1;
            end
            step();
        end
    endtask

    // ---------------- stimulus ----------------
    logic [6:0] v;
    logic [1:0] st_exp [7];
    int         t1, t2;

    initial begin
        cyc       = 0;
        Reiniciar = 1'b1;
        ds = 1'b1; mu = 1'b0;
        ds0 = 1'b1; mu0 = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_tupla",  tupla,  4'h0);
        chk("rst_hab",    hab,    1'b0);
        chk("rst_ocup",   ocup,   1'b0);
        chk("rst_epar",   epar,   1'b0);
        chk("rst_etrama", etrama, 1'b0);
        chk("rst_estado", estado, 2'd0);
        chk("rst_tupla_np", tupla0, 4'h0);
        Reiniciar = 1'b0;
        step();

        // Test 1: good frame 4'hB with parity 1
        exp_q.push_back(4'hB);
        send(0, 8'b0110111, 7);
        chk("t1_hab",    hab,    1'b1);
        chk("t1_tupla",  tupla,  4'hB);
        chk("t1_epar",   epar,   1'b0);
        chk("t1_etrama", etrama, 1'b0);
        chk("t1_ocup",   ocup,   1'b0);
        ds = 1'b1; mu = 1'b1;
        step();
        chk("t1_hab_width", hab, 1'b0);

        // Test 2: same data, parity bit 0 -> parity error
        send(0, 8'b0110101, 7);
        chk("t2_epar",   epar,   1'b1);
        chk("t2_hab",    hab,    1'b0);
        chk("t2_tupla",  tupla,  4'hB);
        chk("t2_etrama", etrama, 1'b0);
        ds = 1'b1;
        step();

        // Test 3: 4'h5 with stop bit 0 -> framing error
        send(0, 8'b0101000, 7);
        chk("t3_etrama", etrama, 1'b1);
        chk("t3_epar",   epar,   1'b0);
        chk("t3_hab",    hab,    1'b0);
        chk("t3_tupla",  tupla,  4'hB);
        ds = 1'b1;

        // Test 4: 4'h6, tick every 3rd cycle; start bit clears ErrorTrama
        exp_q.push_back(4'h6);
        v = 7'b0011001;
        st_exp = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 7; i++) begin
            ds = v[6-i];
            mu = 1'b1;
            step();
            if (i == 0) begin
                chk("t4_etrama_clr", etrama, 1'b0);
                chk("t4_ocup",       ocup,   1'b1);
            end
            if (i == 6) begin
                chk("t4_hab",   hab,   1'b1);
                chk("t4_tupla", tupla, 4'h6);
            end
            mu = 1'b0;
            ds = ~ds;
            step();
            chk("t4_frozen_a", estado, st_exp[i]);
            if (i == 6) chk("t4_hab_width", hab, 1'b0);
            step();
            chk("t4_frozen_b", estado, st_exp[i]);
        end
        ds = 1'b1;

        // Test 5: reset after second data bit, then clean 4'hA
        send(0, 8'b0010101 >> 4, 3);
        chk("t5_ocup_mid", ocup, 1'b1);
        Reiniciar = 1'b1; mu = 1'b1; ds = 1'b0;
        step();
        chk("t5_tupla",  tupla,  4'h0);
        chk("t5_hab",    hab,    1'b0);
        chk("t5_ocup",   ocup,   1'b0);
        chk("t5_epar",   epar,   1'b0);
        chk("t5_etrama", etrama, 1'b0);
        chk("t5_estado", estado, 2'd0);
        Reiniciar = 1'b0; ds = 1'b1;
        step();
        exp_q.push_back(4'hA);
        send(0, 8'b0010101, 7);
        chk("t5_hab_a",   hab,   1'b1);
        chk("t5_tupla_a", tupla, 4'hA);
        ds = 1'b1;
        step();

        // Test 6: back-to-back 4'h3 then 4'hC with parity
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hC);
        send(0, 8'b0110001, 7);
        chk("t6_hab_3",   hab,   1'b1);
        chk("t6_tupla_3", tupla, 4'h3);
        t1 = cyc;
        send(0, 8'b0001101, 7);
        chk("t6_hab_c",   hab,   1'b1);
        chk("t6_tupla_c", tupla, 4'hC);
        t2 = cyc;
        chk("t6_spacing", t2 - t1, 7);
        ds = 1'b1; mu = 1'b0;
        step();

        // Test 6b: same pair without parity (6-tick frames)
        exp_q0.push_back(4'h3);
        exp_q0.push_back(4'hC);
        send(1, 8'b011001, 6);
        chk("t6np_hab_3",   hab0,   1'b1);
        chk("t6np_tupla_3", tupla0, 4'h3);
        t1 = cyc;
        send(1, 8'b000111, 6);
        chk("t6np_hab_c",   hab0,   1'b1);
        chk("t6np_tupla_c", tupla0, 4'hC);
        chk("t6np_epar",    epar0,  1'b0);
        t2 = cyc;
        chk("t6np_spacing", t2 - t1, 6);
        ds0 = 1'b1;
        step();
        chk("t6np_hab_width", hab0, 1'b0);
        step();

        chk("exp_q_drained",    exp_q.size(),  0);
        chk("exp_q_np_drained", exp_q0.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_receptor_serie_tupla
